m1_muldiv_ctrl: RTL and testbench

ABP initiator that sits between the M1 execute stage and the multiplier and divider units. It accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO commands and drives the operands. It toggles the request line of the selected unit, waits for the matching acknowledge, and latches the result into the architectural HI/LO registers. It provides busy_o for pipeline stalls, plus a watchdog that flags lost acknowledges.

---
 rtl/m1_muldiv_ctrl.sv | 148 ++++++++++++++
 tb/tb_m1_muldiv_ctrl.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/m1_muldiv_ctrl.sv
// HI/LO controller for the M1 execute stage: launches MULT/DIV transactions on the
// multiplier/divider over a toggle-level request/acknowledge handshake and owns HI/LO.
module m1_muldiv_ctrl #(
    parameter int unsigned TIMEOUT = 64
) (
    input  logic        sys_clock_i,
    input  logic        sys_reset_i,
    input  logic        op_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    output logic        busy_o,
    output logic        err_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o,
    output logic [31:0] a_o,
    output logic [31:0] b_o,
    output logic        signed_o,
    output logic        mul_req_o,
    input  logic        mul_ack_i,
    input  logic [63:0] mul_product_i,
    output logic        div_req_o,
    input  logic        div_ack_i,
    input  logic [31:0] div_quotient_i,
    input  logic [31:0] div_remainder_i
);

    localparam logic [0:0] StIdle = 1'b0;
    localparam logic [0:0] StWait = 1'b1;

    localparam logic [2:0] OpMthi = 3'd4;
    localparam logic [2:0] OpMtlo = 3'd5;

    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    logic [0:0]  state_q, state_d;
    logic        sel_div_q, sel_div_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] a_q, a_d;
    logic [31:0] b_q, b_d;
    logic        signed_q, signed_d;
    logic        mul_req_q, mul_req_d;
    logic        div_req_q, div_req_d;
    logic        ack_match;

    // Transaction is done once the selected unit's ack level catches up with its request.
    assign ack_match = sel_div_q ? (div_ack_i == div_req_q) : (mul_ack_i == mul_req_q);

    always_comb begin
        state_d   = state_q;
        sel_div_d = sel_div_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        a_d       = a_q;
        b_d       = b_q;
        signed_d  = signed_q;
        mul_req_d = mul_req_q;
        div_req_d = div_req_q;

        case (state_q)
            StIdle: begin
                if (op_valid_i) begin
                    if (op_i[2] == 1'b0) begin
                        a_d       = a_i;
                        b_d       = b_i;
                        signed_d  = op_i[0];
                        err_d     = 1'b0;
                        sel_div_d = op_i[1];
                        cnt_d     = 8'd0;
                        state_d   = StWait;
                        if (op_i[1]) begin
                            div_req_d = ~div_req_q;
                        end else begin
                            mul_req_d = ~mul_req_q;
                        end
                    end else if (op_i == OpMthi) begin
                        hi_d = a_i;
                    end else if (op_i == OpMtlo) begin
                        lo_d = a_i;
                    end
                end
            end
            StWait: begin
                if (ack_match) begin
                    if (sel_div_q) begin
                        lo_d = div_quotient_i;
                        hi_d = div_remainder_i;
                    end else begin
                        hi_d = mul_product_i[63:32];
                        lo_d = mul_product_i[31:0];
                    end
                    state_d = StIdle;
                end else if (cnt_q == CntLast) begin
                    // Abandon: request level stays toggled, so a late ack is simply ignored.
                    err_d   = 1'b1;
                    state_d = StIdle;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge sys_clock_i) begin
        if (!sys_reset_i) begin
            state_q   <= StIdle;
            sel_div_q <= 1'b0;
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            a_q       <= 32'd0;
            b_q       <= 32'd0;
            signed_q  <= 1'b0;
            mul_req_q <= 1'b0;
            div_req_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_div_q <= sel_div_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            a_q       <= a_d;
            b_q       <= b_d;
            signed_q  <= signed_d;
            mul_req_q <= mul_req_d;
            div_req_q <= div_req_d;
        end
    end

    assign busy_o    = (state_q == StWait);
    assign err_o     = err_q;
    assign hi_o      = hi_q;
    assign lo_o      = lo_q;
    assign a_o       = a_q;
    assign b_o       = b_q;
    assign signed_o  = signed_q;
    assign mul_req_o = mul_req_q;
    assign div_req_o = div_req_q;

endmodule

// File: tb/tb_m1_muldiv_ctrl.sv
// Directed bench for m1_muldiv_ctrl with behavioural multiplier/divider units
// that answer a request toggle after a fixed latency.
module tb_m1_muldiv_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, err, signed_o, mul_req, div_req;
    logic [31:0] hi, lo, a_o, b_o;
    logic        mul_ack, div_ack;
    logic [63:0] mul_prod;
    logic [31:0] div_q, div_r;

    int checks = 0;
    int errors = 0;
    int cycles;
    bit div_stall = 1'b0;

    localparam int Lat = 33;

    always #5 clk = ~clk;

    m1_muldiv_ctrl #(.TIMEOUT(64)) dut (
        .sys_clock_i     (clk),
        .sys_reset_i     (rst_n),
        .op_valid_i      (op_valid),
        .op_i            (op),
        .a_i             (a),
        .b_i             (b),
        .busy_o          (busy),
        .err_o           (err),
        .hi_o            (hi),
        .lo_o            (lo),
        .a_o             (a_o),
        .b_o             (b_o),
        .signed_o        (signed_o),
        .mul_req_o       (mul_req),
        .mul_ack_i       (mul_ack),
        .mul_product_i   (mul_prod),
        .div_req_o       (div_req),
        .div_ack_i       (div_ack),
        .div_quotient_i  (div_q),
        .div_remainder_i (div_r)
    );

    function automatic logic [63:0] mulf(input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
        logic [63:0] ex, ey;
        ex = s ? {{32{x[31]}}, x} : {32'd0, x};
        ey = s ? {{32{y[31]}}, y} : {32'd0, y};
        return ex * ey;
    endfunction

    function automatic logic [63:0] divf(input logic [31:0] x, input logic [31:0] y,
                                         input logic s);
        logic [31:0] mx, my, q, r;
        mx = (s && x[31]) ? -x : x;
        my = (s && y[31]) ? -y : y;
        if (y == 32'd0) return {32'hFFFF_FFFF, mx};
        q = mx / my;
        r = mx % my;
        if (s && (x[31] ^ y[31])) q = -q;
        if (s && x[31]) r = -r;
        return {q, r};
    endfunction

    // Multiplier model
    logic mul_seen;
    int   mul_cnt;
    always @(posedge clk) begin
        if (!rst_n) begin
            mul_ack <= 1'b0; mul_seen <= 1'b0; mul_cnt <= 0; mul_prod <= 64'd0;
        end else if (mul_req != mul_seen) begin
            mul_seen <= mul_req; mul_cnt <= Lat; mul_prod <= mulf(a_o, b_o, signed_o);
        end else if (mul_cnt == 1) begin
            mul_ack <= mul_seen; mul_cnt <= 0;
        end else if (mul_cnt > 1) begin
            mul_cnt <= mul_cnt - 1;
        end
    end

    // Divider model; div_stall makes it swallow the request and never answer
    logic        div_seen;
    int          div_cnt;
    logic [63:0] div_res;
    assign div_q = div_res[63:32];
    assign div_r = div_res[31:0];
    always @(posedge clk) begin
        if (!rst_n) begin
            div_ack <= 1'b0; div_seen <= 1'b0; div_cnt <= 0; div_res <= 64'd0;
        end else if (div_req != div_seen) begin
            div_seen <= div_req; div_cnt <= div_stall ? 0 : Lat;
            div_res <= divf(a_o, b_o, signed_o);
        end else if (div_cnt == 1) begin
            div_ack <= div_seen; div_cnt <= 0;
        end else if (div_cnt > 1) begin
            div_cnt <= div_cnt - 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
        op_valid = 1'b1; op = o; a = x; b = y;
        tick();
        op_valid = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int n);
        n = 0;
        while (busy && n < 300) begin
            tick();
            n++;
        end
        check({tag, "_idle"}, {63'd0, busy}, 64'd0);
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        tick();
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_err", {63'd0, err}, 64'd0);
        check("rst_hilo", {hi, lo}, 64'd0);
        check("rst_ab", {a_o, b_o}, 64'd0);
        check("rst_req", {61'd0, signed_o, mul_req, div_req}, 64'd0);

        // MULTU 17*3
        issue(3'd0, 32'd17, 32'd3);
        check("multu_busy", {63'd0, busy}, 64'd1);
        check("multu_req", {62'd0, mul_req, div_req}, 64'd2);
        check("multu_ops", {a_o, b_o}, {32'd17, 32'd3});
        wait_idle("multu", cycles);
        check("multu_lat", {63'd0, cycles > 20}, 64'd1);
        check("multu_res", {hi, lo}, {32'd0, 32'd51});
        check("multu_err", {63'd0, err}, 64'd0);

        // MULT -7*3, then MULT 5*-2
        issue(3'd1, 32'hFFFF_FFF9, 32'd3);
        check("mult_req", {62'd0, mul_req, signed_o}, 64'd1);
        wait_idle("mult", cycles);
        check("mult_res", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFEB});
        issue(3'd1, 32'd5, 32'hFFFF_FFFE);
        check("mult2_req", {63'd0, mul_req}, 64'd1);
        wait_idle("mult2", cycles);
        check("mult2_res", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFF6});

        // DIVU 17/5, DIV 20/4
        issue(3'd2, 32'd17, 32'd5);
        check("divu_req", {62'd0, mul_req, div_req}, 64'd3);
        wait_idle("divu", cycles);
        check("divu_res", {hi, lo}, {32'd2, 32'd3});
        issue(3'd3, 32'd20, 32'd4);
        check("div_req", {62'd0, mul_req, div_req}, 64'd2);
        wait_idle("div", cycles);
        check("div_res", {hi, lo}, {32'd0, 32'd5});

        // MTHI then MTLO on consecutive cycles
        op_valid = 1'b1; op = 3'd4; a = 32'hDEAD_BEEF;
        tick();
        check("mthi", {31'd0, busy, hi}, {32'd0, 32'hDEAD_BEEF});
        op = 3'd5; a = 32'h1234_5678;
        tick();
        op_valid = 1'b0;
        check("mtlo", {31'd0, busy, lo}, {32'd0, 32'h1234_5678});
        check("mt_noabp", {62'd0, mul_req, div_req}, 64'd2);

        // Reserved op ignored
        op_valid = 1'b1; op = 3'd7; a = 32'h5555_5555;
        tick();
        op_valid = 1'b0;
        check("rsvd", {hi, lo}, {32'hDEAD_BEEF, 32'h1234_5678});
        check("rsvd_busy", {63'd0, busy}, 64'd0);

        // MULTU 2*3, with a held MULTU ignored while busy
        issue(3'd0, 32'd2, 32'd3);
        op_valid = 1'b1; op = 3'd0; a = 32'd9; b = 32'd9;
        repeat (5) tick();
        op_valid = 1'b0;
        check("busy_ign_req", {63'd0, mul_req}, 64'd0);
        check("busy_ign_ops", {a_o, b_o}, {32'd2, 32'd3});
        wait_idle("busyign", cycles);
        check("busy_ign_res", {hi, lo}, {32'd0, 32'd6});

        // Divider that never answers: watchdog after 64 WAIT cycles
        div_stall = 1'b1;
        issue(3'd2, 32'd7, 32'd1);
        check("to_req", {63'd0, div_req}, 64'd1);
        wait_idle("timeout", cycles);
        check("to_cycles", 64'(cycles), 64'd64);
        check("to_err", {63'd0, err}, 64'd1);
        check("to_hilo", {hi, lo}, {32'd0, 32'd6});
        check("to_req_kept", {63'd0, div_req}, 64'd1);
        issue(3'd0, 32'd4, 32'd5);
        check("to_clear", {63'd0, err}, 64'd0);
        wait_idle("after_to", cycles);
        check("after_to_res", {hi, lo}, {32'd0, 32'd20});

        // Reset mid-WAIT
        issue(3'd0, 32'd100, 32'd100);
        repeat (5) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check("mrst_state", {59'd0, busy, err, signed_o, mul_req, div_req}, 64'd0);
        check("mrst_hilo", {hi, lo}, 64'd0);
        check("mrst_ab", {a_o, b_o}, 64'd0);
        tick();
        issue(3'd0, 32'd6, 32'd7);
        check("post_rst_req", {63'd0, mul_req}, 64'd1);
        wait_idle("post_rst", cycles);
        check("post_rst_res", {hi, lo}, {32'd0, 32'd42});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
